alu_arbiter: RTL and testbench

- Shares the single execute-stage ALU between two requesters: requester 0 is the pipeline EX path, requester 1 is the auxiliary/debug issue port.
- Round-robin arbitration feeds a one-entry issue register, which drives the ALU. The ALU result is captured into a one-entry response register tagged with the requester id.
- Full valid/ready backpressure through both stages.
- Also keeps the sticky pass/done indication that the ALU raises on MTC0 DONE.

---
 rtl/alu_arbiter.sv | 114 +++++++++++
 tb/tb_alu_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of the execute-stage ALU between the EX path (0)
// and the aux/debug port (1), with issue/response registers and a sticky DONE flag.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CTL_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*CTL_WIDTH-1:0]  req_ctl,
    input  logic [2*DATA_WIDTH-1:0] req_op1,
    input  logic [2*DATA_WIDTH-1:0] req_op2,
    output logic                    alu_valid,
    output logic [CTL_WIDTH-1:0]    alu_ctl,
    output logic [DATA_WIDTH-1:0]   alu_op1,
    output logic [DATA_WIDTH-1:0]   alu_op2,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic                    alu_branch_taken,
    input  logic                    alu_done,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [DATA_WIDTH-1:0]   rsp_result,
    output logic                    rsp_branch_taken,
    output logic                    done
);

    logic                  rsp_load;
    logic                  iss_free;
    logic [1:0]            grant;
    logic                  accept;
    logic                  sel;
    logic                  ptr;
    logic                  iss_id;
    logic [CTL_WIDTH-1:0]  sel_ctl;
    logic [DATA_WIDTH-1:0] sel_op1;
    logic [DATA_WIDTH-1:0] sel_op2;

    assign rsp_load = alu_valid && (!rsp_valid || rsp_ready);
    assign iss_free = !alu_valid || rsp_load;

    // rst_n gates the grant so nothing is offered to requesters while in reset
    always_comb begin
        grant = 2'b00;
        if (rst_n && iss_free && !flush) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign sel       = grant[1];

    assign sel_ctl = sel ? req_ctl[2*CTL_WIDTH-1:CTL_WIDTH]    : req_ctl[CTL_WIDTH-1:0];
    assign sel_op1 = sel ? req_op1[2*DATA_WIDTH-1:DATA_WIDTH] : req_op1[DATA_WIDTH-1:0];
    assign sel_op2 = sel ? req_op2[2*DATA_WIDTH-1:DATA_WIDTH] : req_op2[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_valid <= 1'b0;
            alu_ctl   <= '0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            iss_id    <= 1'b0;
            ptr       <= 1'b0;
        end else if (flush) begin
            alu_valid <= 1'b0;
        end else if (accept) begin
            alu_valid <= 1'b1;
            alu_ctl   <= sel_ctl;
            alu_op1   <= sel_op1;
            alu_op2   <= sel_op2;
            iss_id    <= sel;
            ptr       <= ~sel;
        end else if (iss_free) begin
            alu_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid        <= 1'b0;
            rsp_id           <= 1'b0;
            rsp_result       <= '0;
            rsp_branch_taken <= 1'b0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (rsp_load) begin
            rsp_valid        <= 1'b1;
            rsp_id           <= iss_id;
            rsp_result       <= alu_result;
            rsp_branch_taken <= alu_branch_taken;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Sticky until reset; a flush in the same cycle suppresses the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else if (alu_valid && alu_done && !flush) begin
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level model and an in-order response scoreboard.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int CW = 5;

    localparam logic [CW-1:0] C_ADD  = 5'd0;
    localparam logic [CW-1:0] C_SUB  = 5'd1;
    localparam logic [CW-1:0] C_OR   = 5'd2;
    localparam logic [CW-1:0] C_AND  = 5'd3;
    localparam logic [CW-1:0] C_XOR  = 5'd4;
    localparam logic [CW-1:0] C_BEQ  = 5'd5;
    localparam logic [CW-1:0] C_BNE  = 5'd6;
    localparam logic [CW-1:0] C_DONE = 5'd7;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*CW-1:0] req_ctl;
    logic [2*DW-1:0] req_op1;
    logic [2*DW-1:0] req_op2;
    logic            alu_valid;
    logic [CW-1:0]   alu_ctl;
    logic [DW-1:0]   alu_op1;
    logic [DW-1:0]   alu_op2;
    logic [DW-1:0]   alu_result;
    logic            alu_branch_taken;
    logic            alu_done;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [DW-1:0]   rsp_result;
    logic            rsp_branch_taken;
    logic            done;

    alu_arbiter #(.DATA_WIDTH(DW), .CTL_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ctl(req_ctl), .req_op1(req_op1), .req_op2(req_op2),
        .alu_valid(alu_valid), .alu_ctl(alu_ctl), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_branch_taken(alu_branch_taken), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_branch_taken(rsp_branch_taken), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_res(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (c)
            C_ADD:        return a + b;
            C_SUB, C_BEQ,
            C_BNE:        return a - b;
            C_OR:         return a | b;
            C_AND:        return a & b;
            C_XOR:        return a ^ b;
            default:      return '0;
        endcase
    endfunction

    function automatic logic alu_bt(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b);
        return (c == C_BEQ && a == b) || (c == C_BNE && a != b);
    endfunction

    // Behavioural ALU standing in for the real execute unit
    always_comb begin
        alu_result       = alu_res(alu_ctl, alu_op1, alu_op2);
        alu_branch_taken = alu_bt(alu_ctl, alu_op1, alu_op2);
        alu_done         = (alu_ctl == C_DONE);
    end

    typedef struct packed {
        logic          id;
        logic [DW-1:0] res;
        logic          bt;
    } rsp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    rsp_t exp_q[$];
    logic [DW-1:0] obs_q[$];
    logic [1:0]    glog[$];
    logic [1:0]    last_grant;

    // Model: what sits in the issue slot and the response slot, plus pointer/done
    logic          m_iv, m_iid, m_rv, m_rid, m_rbt, m_ptr, m_done;
    logic [CW-1:0] m_ictl;
    logic [DW-1:0] m_iop1, m_iop2, m_rres;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_iv = 0; m_iid = 0; m_rv = 0; m_rid = 0; m_rbt = 0; m_ptr = 0; m_done = 0;
        m_ictl = '0; m_iop1 = '0; m_iop2 = '0; m_rres = '0;
        exp_q.delete();
        last_grant = 2'b00;
    endtask

    task automatic set_req(input int k, input logic v, input logic [CW-1:0] c,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid[k]        = v;
        req_ctl[k*CW +: CW] = c;
        req_op1[k*DW +: DW] = a;
        req_op2[k*DW +: DW] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_alu_valid", 64'(alu_valid), 64'(0));
        chk("rst_alu_op1", 64'(alu_op1), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_result", 64'(rsp_result), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // One clock: check DUT against model with current inputs, then advance the model
    task automatic cycle();
        logic       free;
        logic [1:0] g;
        logic       k;
        rsp_t       e;
        #1;
        free = !m_iv || !m_rv || rsp_ready;
        g = 2'b00;
        if (free && !flush)
            g = (req_valid == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : req_valid;
        chk("req_ready", 64'(req_ready), 64'(g));
        chk("alu_valid", 64'(alu_valid), 64'(m_iv));
        if (m_iv) begin
            chk("alu_ctl", 64'(alu_ctl), 64'(m_ictl));
            chk("alu_op1", 64'(alu_op1), 64'(m_iop1));
            chk("alu_op2", 64'(alu_op2), 64'(m_iop2));
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
        if (m_rv) begin
            chk("rsp_id", 64'(rsp_id), 64'(m_rid));
            chk("rsp_result", 64'(rsp_result), 64'(m_rres));
            chk("rsp_bt", 64'(rsp_branch_taken), 64'(m_rbt));
        end
        chk("done", 64'(done), 64'(m_done));
        if (rsp_valid && rsp_ready && !flush) begin
            obs_q.push_back(rsp_result);
            if (exp_q.size() == 0) begin
                chk("sb_extra_rsp", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_id", 64'(rsp_id), 64'(e.id));
                chk("sb_result", 64'(rsp_result), 64'(e.res));
            end
        end
        @(posedge clk);
        if (m_iv && m_ictl == C_DONE && !flush) m_done = 1;
        if (flush) begin
            m_iv = 0;
            m_rv = 0;
            exp_q.delete();
        end else begin
            if (m_iv && (!m_rv || rsp_ready)) begin
                m_rv   = 1;
                m_rid  = m_iid;
                m_rres = alu_res(m_ictl, m_iop1, m_iop2);
                m_rbt  = alu_bt(m_ictl, m_iop1, m_iop2);
            end else if (m_rv && rsp_ready) begin
                m_rv = 0;
            end
            if (g != 2'b00) begin
                k      = g[1];
                m_iv   = 1;
                m_iid  = k;
                m_ictl = req_ctl[int'(k)*CW +: CW];
                m_iop1 = req_op1[int'(k)*DW +: DW];
                m_iop2 = req_op2[int'(k)*DW +: DW];
                m_ptr  = ~k;
                exp_q.push_back('{id: k, res: alu_res(m_ictl, m_iop1, m_iop2), bt: 1'b0});
            end else if (free) begin
                m_iv = 0;
            end
        end
        last_grant = g;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] rand_ctl();
        case ($urandom_range(0, 7))
            0: return C_ADD;
            1: return C_SUB;
            2: return C_OR;
            3: return C_AND;
            4: return C_XOR;
            5: return C_BEQ;
            6: return C_BNE;
            default: return C_DONE;
        endcase
    endfunction

    initial begin
        rst_n = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
        req_valid = 2'b00; req_ctl = '0; req_op1 = '0; req_op2 = '0;
        model_reset();
        set_req(0, 1'b1, C_ADD, 32'd5, 32'd7);
        #1;
        do_reset();

        // Single request on requester 0
        rsp_ready = 1'b1;
        #1;
        chk("t1_req_ready", 64'(req_ready), 64'(2'b01));
        cycle();
        req_valid = 2'b00;
        chk("t1_alu_valid", 64'(alu_valid), 64'(1));
        chk("t1_alu_op1", 64'(alu_op1), 64'(5));
        chk("t1_alu_op2", 64'(alu_op2), 64'(7));
        cycle();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("t1_rsp_id", 64'(rsp_id), 64'(0));
        chk("t1_rsp_result", 64'(rsp_result), 64'(12));
        cycle();

        // Continuous dual requests alternate, starting with requester 0 after reset
        do_reset();
        set_req(0, 1'b1, C_SUB, 32'd9, 32'd4);
        set_req(1, 1'b1, C_OR, 32'hF0, 32'h0F);
        rsp_ready = 1'b1;
        obs_q.delete();
        glog.delete();
        for (int i = 0; i < 6; i++) begin
            cycle();
            glog.push_back(last_grant);
        end
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) cycle();
        chk("t2_grants", 64'(glog.size()), 64'(6));
        foreach (glog[i]) chk("t2_grant_order", 64'(glog[i]), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
        chk("t2_rsp_count", 64'(obs_q.size()), 64'(6));
        foreach (obs_q[i]) chk("t2_rsp_alt", 64'(obs_q[i]), 64'((i % 2 == 0) ? 32'd5 : 32'hFF));

        // Fill, stall three cycles, then drain
        req_valid = 2'b11;
        cycle();
        cycle();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_ready", 64'(req_ready), 64'(0));
            cycle();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("t3_drained", 64'(exp_q.size()), 64'(0));

        // Branch outcomes on requester 1
        set_req(1, 1'b1, C_BEQ, 32'd3, 32'd3);
        cycle();
        set_req(1, 1'b1, C_BNE, 32'd3, 32'd3);
        cycle();
        chk("t4_beq_taken", 64'(rsp_branch_taken), 64'(1));
        chk("t4_beq_id", 64'(rsp_id), 64'(1));
        req_valid = 2'b00;
        cycle();
        chk("t4_bne_taken", 64'(rsp_branch_taken), 64'(0));
        cycle();

        // Flush with both stages occupied
        set_req(0, 1'b1, C_ADD, 32'd1, 32'd1);
        cycle();
        set_req(0, 1'b1, C_ADD, 32'd2, 32'd2);
        rsp_ready = 1'b0;
        cycle();
        set_req(0, 1'b1, C_ADD, 32'd20, 32'd22);
        flush = 1'b1;
        #1;
        chk("t5_flush_ready", 64'(req_ready), 64'(0));
        cycle();
        flush = 1'b0;
        chk("t5_alu_valid", 64'(alu_valid), 64'(0));
        chk("t5_rsp_valid", 64'(rsp_valid), 64'(0));
        cycle();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        cycle();
        chk("t5_after_valid", 64'(rsp_valid), 64'(1));
        chk("t5_after_result", 64'(rsp_result), 64'(42));
        cycle();

        // Sticky DONE, survives flush, cleared by async reset mid-operation
        set_req(0, 1'b1, C_DONE, 32'd0, 32'd0);
        cycle();
        req_valid = 2'b00;
        chk("t6_done_pre", 64'(done), 64'(0));
        cycle();
        chk("t6_done_set", 64'(done), 64'(1));
        set_req(0, 1'b1, C_ADD, 32'd4, 32'd4);
        cycle();
        req_valid = 2'b00;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("t6_done_hold", 64'(done), 64'(1));
        set_req(1, 1'b1, C_XOR, 32'hA5, 32'h5A);
        cycle();
        cycle();
        do_reset();

        // Randomized traffic; pending requesters keep their payload stable
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(req_valid[k] && !last_grant[k])) begin
                    logic [DW-1:0] a;
                    logic [DW-1:0] b;
                    a = $urandom();
                    b = ($urandom_range(0, 1) == 1) ? a : $urandom();
                    set_req(k, ($urandom_range(0, 3) != 0), rand_ctl(), a, b);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("rand_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
